// File: rtl/uart_tx_io_pkg.sv
// Shared UART definitions: data width and transmitter FSM state encoding.
// Kept symmetric with the bootloader RX path.
package uart_tx_io_pkg;
   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;
endpackage

// File: rtl/uart_tx_io_tx_fifo.sv
// Small synchronous FIFO with a separately kept occupancy count.
// A push is judged against the count before any same-cycle pop.
import uart_tx_io_pkg::*;

module tx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = UART_DATA_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign do_push = push_i && (count_q != FULL_CNT);
   assign do_pop  = pop_i && (count_q != '0);

   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter: write strobe into a FIFO, FSM serializes
// LSB first, sticky overflow flag and FIFO status for CPU polling.
import uart_tx_io_pkg::*;

module uart_tx_io #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_en,
   input  logic [UART_DATA_W-1:0]      wr_data,
   input  logic                        clr_ovf,
   output logic                        TX,
   output logic                        tx_busy,
   output logic                        tx_full,
   output logic                        tx_empty,
   output logic                        tx_ovf,
   output logic [$clog2(FIFO_DEPTH):0] tx_level
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_t              state_q, state_d;
   logic [BW-1:0]          baud_q, baud_d;
   logic [2:0]             bit_q, bit_d;
   logic [UART_DATA_W-1:0] shift_q, shift_d;
   logic                   tx_q, tx_d;
   logic                   ovf_q, ovf_d;
   logic                   pop;
   logic                   bit_end;
   logic [UART_DATA_W-1:0] fifo_rdata;
   logic                   fifo_full, fifo_empty;

   tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (wr_en),
      .wdata_i (wr_data),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (tx_level)
   );

   assign bit_end = (baud_q == BAUD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_rdata;
               baud_d  = '0;
               bit_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[UART_DATA_W-1:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            // Popping on the last stop cycle keeps back-to-back frames gapless.
            if (bit_end) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_rdata;
                  bit_d   = '0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // A dropped write outranks a same-cycle clear.
      if (wr_en && fifo_full) ovf_d = 1'b1;
      else if (clr_ovf)       ovf_d = 1'b0;
      else                    ovf_d = ovf_q;
   end

   always_comb begin
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   assign TX       = tx_q;
   assign tx_busy  = (state_q != IDLE);
   assign tx_full  = fifo_full;
   assign tx_empty = fifo_empty;
   assign tx_ovf   = ovf_q;
endmodule
